joy_dir_resolver: RTL and testbench
===================================

JOY_DIR_RESOLVER -- requirements
Module: joy_dir_resolver

Interface
REQ-001 SHALL provide parameter NP, default 2, number of players.
REQ-002 SHALL provide parameter AF_HALF, default 819200, autofire half-period in clk cycles (about 15 Hz at 24.576 MHz).
REQ-003 SHALL provide port clk, input, 1, system clock; all logic runs in this single clock domain.
REQ-004 SHALL provide port reset, input, 1, reset; synchronous, active-high.
REQ-005 SHALL provide port joy_in, input, 4*NP, raw directions per player p at [4p+3:4p] = {U,D,L,R}, active-high.
REQ-006 SHALL provide port fire_in, input, NP, raw fire per player, active-high.
REQ-007 SHALL provide port opp_mode, input, 2, opposite-direction policy: 00 last-wins, 01 neutral, 10 first-wins, 11 treated as 00.
REQ-008 SHALL provide port four_way, input, 1; when 1, diagonals are suppressed.
REQ-009 SHALL provide port af_en, input, NP, per-player autofire enable.
REQ-010 SHALL provide port joy_out, output, 4*NP, resolved directions, same bit layout as joy_in.
REQ-011 SHALL provide port fire_out, output, NP, resolved fire.

Function
REQ-012 SHALL pass joy_in and fire_in through two register stages (s1, s2); press edge = s1 & ~s2.
REQ-013 SHALL register joy_out from s1 and edge state, so an input stable from edge k appears on joy_out at edge k+2.
REQ-014 SHALL store, per player and axis, a last-pressed record updated on each press edge; simultaneous edges on both sides record U (vertical) or R (horizontal).
REQ-015 When only one side of an axis is held, it SHALL output that side unchanged, in all modes.
REQ-016 When both sides are held, last-wins SHALL output the recorded side, and first-wins SHALL output the side held longer; a simultaneous-edge tie resolves to U or R.
REQ-017 When both sides are held and opp_mode=01, the axis output SHALL be 00.
REQ-018 In first-wins, releasing the held-first side while the other stays held SHALL hand output to the remaining side on the next registered update.
REQ-019 With four_way=1 and both axes non-zero after REQ-015..017, it SHALL output only the axis with the most recent press edge (tracked in a last_axis register); a tie resolves to vertical.
REQ-020 With af_en[p]=0, fire_out[p] SHALL equal s1 fire with the same two-cycle latency as directions.
REQ-021 With af_en[p]=1 and fire held, fire_out[p] SHALL be high for AF_HALF cycles starting at the first registered cycle, then alternate low and high every AF_HALF cycles.
REQ-022 On fire release, the autofire counter and phase SHALL clear, and fire_out[p] SHALL go low on the same cycle that a non-autofire output would.
REQ-023 Changing opp_mode or four_way SHALL take effect on the next registered output, with no history cleared.
REQ-024 Players SHALL be fully independent.

Reset
REQ-025 While reset=1, joy_out, fire_out, s1, s2, last-pressed records, last_axis, autofire counters and phases SHALL be 0 at each clock edge.
REQ-026 Inputs held through reset release SHALL be seen as press edges one cycle after release and resolved per REQ-014.

Structure
REQ-027 Shared package joy_pkg SHALL hold the opp_mode encoding constants and the U/D/L/R bit-index constants.
REQ-028 A sub-module joy_axis SHALL resolve one axis (two inputs, edges, mode) and be instantiated 2*NP times; autofire logic stays in the parent.

Verification
REQ-029 Scenario: P0 press R, 5 cycles later L, both held, opp_mode=00 -> joy_out[1:0]=01 then 10 two cycles after L.
REQ-030 Scenario: same stimulus with opp_mode=10 -> stays 01; release R -> 10; with opp_mode=01 -> 00 while both held.
REQ-031 Scenario: U and D rise same cycle, opp_mode=00 -> joy_out[3:2]=10 (U).
REQ-032 Scenario: four_way=1, press U then R -> joy_out=0001; release R -> 1000.
REQ-033 Scenario: AF_HALF=4, af_en=1, fire held 20 cycles -> fire_out pattern 4 high / 4 low from cycle 2; release -> low, counter cleared.
REQ-034 Scenario: assert reset mid-hold with NP=2 -> all outputs 0 next edge; release with inputs held -> outputs restored by cycle 3.

Source files
------------

// File: rtl/joy_pkg.sv
// joy_pkg: shared opposite-direction policy codes and direction bit indices
package joy_pkg;
    localparam logic [1:0] OPP_LAST    = 2'b00;
    localparam logic [1:0] OPP_NEUTRAL = 2'b01;
    localparam logic [1:0] OPP_FIRST   = 2'b10;
    localparam int B_U = 3;
    localparam int B_D = 2;
    localparam int B_L = 1;
    localparam int B_R = 0;
endpackage

// File: rtl/joy_axis.sv
// joy_axis: resolves one axis (pri wins ties: U or R) under the opposite-direction policy
module joy_axis
    import joy_pkg::*;
(
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       pri,
    input  logic       sec,
    input  logic       pri_edge,
    input  logic       sec_edge,
    input  logic [1:0] opp_mode,
    output logic [1:0] res
);
    logic last, tie, last_n, tie_n, win_pri;
    logic [1:0] mode;
    always_comb begin
        mode    = opp_mode == 2'b11 ? OPP_LAST : opp_mode;
        last_n  = pri_edge ? 1'b1 : sec_edge ? 1'b0 : last;
        tie_n   = (pri_edge | sec_edge) ? (pri_edge & sec_edge) : tie;
        win_pri = mode == OPP_FIRST ? (tie_n | ~last_n) : last_n;
        res     = !(pri & sec) ? {pri, sec} : mode == OPP_NEUTRAL ? 2'b00 : {win_pri, ~win_pri};
    end
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            last <= 1'b0;
            tie  <= 1'b0;
        end else begin
            last <= last_n;
            tie  <= tie_n;
        end
    end
endmodule

// File: rtl/joy_dir_resolver.sv
// joy_dir_resolver: per-player SOCD/four-way direction resolution with autofire
module joy_dir_resolver
    import joy_pkg::*;
#(
    parameter int NP      = 2,
    parameter int AF_HALF = 819200
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4*NP-1:0] joy_in,
    input  logic [NP-1:0]   fire_in,
    input  logic [1:0]      opp_mode,
    input  logic            four_way,
    input  logic [NP-1:0]   af_en,
    output logic [4*NP-1:0] joy_out,
    output logic [NP-1:0]   fire_out
);
    localparam int CW = $clog2(AF_HALF + 1);
    logic [4*NP-1:0] js1, js2, jedge, joy_nxt;
    logic [NP-1:0] fs1, fs2, fedge, fire_nxt, phase, phase_nxt, last_axis, la_nxt;
    logic [NP-1:0][CW-1:0] cnt, cnt_nxt;
    assign jedge = js1 & ~js2;
    assign fedge = fs1 & ~fs2;
    for (genvar p = 0; p < NP; p++) begin : g_pl
        logic [1:0] v, h;
        logic v_edge, h_edge, run, wrap;
        joy_axis u_v (
            .clk_sys(clk), .reset(reset),
            .pri(js1[4*p+B_U]), .sec(js1[4*p+B_D]),
            .pri_edge(jedge[4*p+B_U]), .sec_edge(jedge[4*p+B_D]),
            .opp_mode(opp_mode), .res(v)
        );
        joy_axis u_h (
            .clk_sys(clk), .reset(reset),
            .pri(js1[4*p+B_R]), .sec(js1[4*p+B_L]),
            .pri_edge(jedge[4*p+B_R]), .sec_edge(jedge[4*p+B_L]),
            .opp_mode(opp_mode), .res(h)
        );
        assign v_edge = jedge[4*p+B_U] | jedge[4*p+B_D];
        assign h_edge = jedge[4*p+B_R] | jedge[4*p+B_L];
        // last_axis: 0 = vertical, 1 = horizontal; a same-cycle press on both favours vertical
        assign la_nxt[p] = v_edge ? 1'b0 : h_edge ? 1'b1 : last_axis[p];
        assign joy_nxt[4*p+:4] = (four_way && |v && |h) ? (la_nxt[p] ? {2'b00, h[0], h[1]} : {v, 2'b00})
                                                        : {v, h[0], h[1]};
        assign run  = af_en[p] & fs1[p];
        assign wrap = cnt[p] == CW'(AF_HALF - 1);
        assign cnt_nxt[p]   = (!run || wrap) ? '0 : cnt[p] + 1'b1;
        assign phase_nxt[p] = run & (phase[p] ^ wrap);
        assign fire_nxt[p]  = af_en[p] ? fs1[p] & (fedge[p] | ~phase[p]) : fs1[p];
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            js1       <= '0;
            js2       <= '0;
            fs1       <= '0;
            fs2       <= '0;
            joy_out   <= '0;
            fire_out  <= '0;
            last_axis <= '0;
            phase     <= '0;
            cnt       <= '0;
        end else begin
            js1       <= joy_in;
            js2       <= js1;
            fs1       <= fire_in;
            fs2       <= fs1;
            joy_out   <= joy_nxt;
            fire_out  <= fire_nxt;
            last_axis <= la_nxt;
            phase     <= phase_nxt;
            cnt       <= cnt_nxt;
        end
    end
endmodule

// File: tb/tb_joy_dir_resolver.sv
// tb_joy_dir_resolver: directed scenario tests for joy_dir_resolver
module tb_joy_dir_resolver;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] joy_in;
    logic [1:0] fire_in;
    logic [1:0] opp_mode;
    logic       four_way;
    logic [1:0] af_en;
    logic [7:0] joy_out;
    logic [1:0] fire_out;
    int errors = 0;
    int checks = 0;
    joy_dir_resolver #(.NP(2), .AF_HALF(4)) dut (
        .clk(clk), .reset(reset), .joy_in(joy_in), .fire_in(fire_in),
        .opp_mode(opp_mode), .four_way(four_way), .af_en(af_en),
        .joy_out(joy_out), .fire_out(fire_out)
    );
    always #5 clk = ~clk;
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic idle();
        joy_in  = '0;
        fire_in = '0;
        tick(3);
    endtask
    task automatic test_reset();
        reset = 1'b1; joy_in = 8'hA5; fire_in = 2'b11; opp_mode = 2'b00; four_way = 1'b0; af_en = 2'b00;
        tick(3);
        checks++;
        if (joy_out !== 8'h00) begin errors++; $display("FAIL reset_joy: got %h want 00", joy_out); end
        checks++;
        if (fire_out !== 2'b00) begin errors++; $display("FAIL reset_fire: got %b want 00", fire_out); end
        joy_in = '0; fire_in = '0;
        tick(1);
        reset = 1'b0;
        tick(3);
    endtask
    task automatic test_last_wins();
        opp_mode = 2'b00;
        joy_in = 8'h01;
        tick(2);
        checks++;
        if (joy_out !== 8'h01) begin errors++; $display("FAIL lw_r: got %h want 01", joy_out); end
        tick(3);
        joy_in = 8'h03;
        tick(1);
        checks++;
        if (joy_out !== 8'h01) begin errors++; $display("FAIL lw_latency: got %h want 01", joy_out); end
        tick(1);
        checks++;
        if (joy_out !== 8'h02) begin errors++; $display("FAIL lw_l: got %h want 02", joy_out); end
        idle();
    endtask
    task automatic test_first_wins_neutral();
        opp_mode = 2'b10;
        joy_in = 8'h01;
        tick(5);
        joy_in = 8'h03;
        tick(2);
        checks++;
        if (joy_out !== 8'h01) begin errors++; $display("FAIL fw_hold: got %h want 01", joy_out); end
        joy_in = 8'h02;
        tick(2);
        checks++;
        if (joy_out !== 8'h02) begin errors++; $display("FAIL fw_handover: got %h want 02", joy_out); end
        opp_mode = 2'b01;
        joy_in = 8'h03;
        tick(2);
        checks++;
        if (joy_out !== 8'h00) begin errors++; $display("FAIL neutral: got %h want 00", joy_out); end
        opp_mode = 2'b00;
        tick(1);
        checks++;
        if (joy_out !== 8'h01) begin errors++; $display("FAIL mode_to_lw: got %h want 01", joy_out); end
        opp_mode = 2'b10;
        tick(1);
        checks++;
        if (joy_out !== 8'h02) begin errors++; $display("FAIL mode_to_fw: got %h want 02", joy_out); end
        opp_mode = 2'b11;
        tick(1);
        checks++;
        if (joy_out !== 8'h01) begin errors++; $display("FAIL mode_11: got %h want 01", joy_out); end
        opp_mode = 2'b00;
        idle();
    endtask
    task automatic test_tie();
        joy_in = 8'h0C;
        tick(2);
        checks++;
        if (joy_out !== 8'h08) begin errors++; $display("FAIL tie_ud_lw: got %h want 08", joy_out); end
        opp_mode = 2'b10;
        tick(1);
        checks++;
        if (joy_out !== 8'h08) begin errors++; $display("FAIL tie_ud_fw: got %h want 08", joy_out); end
        idle();
        opp_mode = 2'b00;
        joy_in = 8'h03;
        tick(2);
        checks++;
        if (joy_out !== 8'h01) begin errors++; $display("FAIL tie_lr_lw: got %h want 01", joy_out); end
        idle();
    endtask
    task automatic test_four_way();
        four_way = 1'b1;
        joy_in = 8'h08;
        tick(2);
        checks++;
        if (joy_out !== 8'h08) begin errors++; $display("FAIL fourway_u: got %h want 08", joy_out); end
        joy_in = 8'h09;
        tick(2);
        checks++;
        if (joy_out !== 8'h01) begin errors++; $display("FAIL fourway_ur: got %h want 01", joy_out); end
        joy_in = 8'h08;
        tick(2);
        checks++;
        if (joy_out !== 8'h08) begin errors++; $display("FAIL fourway_rel_r: got %h want 08", joy_out); end
        idle();
        joy_in = 8'h09;
        tick(2);
        checks++;
        if (joy_out !== 8'h08) begin errors++; $display("FAIL fourway_tie: got %h want 08", joy_out); end
        four_way = 1'b0;
        tick(1);
        checks++;
        if (joy_out !== 8'h09) begin errors++; $display("FAIL eightway_diag: got %h want 09", joy_out); end
        four_way = 1'b1;
        tick(1);
        checks++;
        if (joy_out !== 8'h08) begin errors++; $display("FAIL fourway_resume: got %h want 08", joy_out); end
        four_way = 1'b0;
        idle();
    endtask
    task automatic test_independence();
        joy_in = 8'h24;
        tick(2);
        checks++;
        if (joy_out !== 8'h24) begin errors++; $display("FAIL indep_a: got %h want 24", joy_out); end
        joy_in = 8'h34;
        tick(2);
        checks++;
        if (joy_out !== 8'h14) begin errors++; $display("FAIL indep_b: got %h want 14", joy_out); end
        idle();
    endtask
    task automatic test_autofire();
        logic exp;
        af_en = 2'b01;
        fire_in = 2'b11;
        for (int i = 1; i <= 21; i++) begin
            if (i == 21) fire_in = 2'b00;
            tick(1);
            exp = (i >= 2) && ((((i - 2) / 4) % 2) == 0);
            checks++;
            if (fire_out !== {i >= 2, exp}) begin
                errors++;
                $display("FAIL af_pattern cyc %0d: got %b want %b", i, fire_out, {i >= 2, exp});
            end
        end
        tick(1);
        checks++;
        if (fire_out !== 2'b00) begin errors++; $display("FAIL af_release: got %b want 00", fire_out); end
        tick(2);
        fire_in = 2'b01;
        for (int i = 1; i <= 7; i++) begin
            tick(1);
            exp = (i >= 2) && (i <= 5);
            checks++;
            if (fire_out[0] !== exp) begin
                errors++;
                $display("FAIL af_restart cyc %0d: got %b want %b", i, fire_out[0], exp);
            end
        end
        af_en = 2'b00;
        idle();
    endtask
    task automatic test_reset_mid_hold();
        joy_in = 8'h81;
        fire_in = 2'b11;
        tick(2);
        checks++;
        if (joy_out !== 8'h81 || fire_out !== 2'b11) begin
            errors++; $display("FAIL hold_pre: got %h/%b want 81/11", joy_out, fire_out);
        end
        reset = 1'b1;
        tick(1);
        checks++;
        if (joy_out !== 8'h00 || fire_out !== 2'b00) begin
            errors++; $display("FAIL hold_reset: got %h/%b want 00/00", joy_out, fire_out);
        end
        tick(1);
        reset = 1'b0;
        tick(1);
        checks++;
        if (joy_out !== 8'h00) begin errors++; $display("FAIL rel_first: got %h want 00", joy_out); end
        tick(1);
        checks++;
        if (joy_out !== 8'h81 || fire_out !== 2'b11) begin
            errors++; $display("FAIL rel_restored: got %h/%b want 81/11", joy_out, fire_out);
        end
        idle();
    endtask
    initial begin
        test_reset();
        test_last_wins();
        test_first_wins_neutral();
        test_tie();
        test_four_way();
        test_independence();
        test_autofire();
        test_reset_mid_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
